// File: rtl/rf68000_node_pkg.sv
// rtl/rf68000_node_pkg.sv - shared types and helpers for the node RAM arbiter
package rf68000_node_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_ACK} state_t;

  localparam logic TRUE   = 1'b1;
  localparam logic FALSE  = 1'b0;
  localparam int   CNT_W  = 2;
  localparam int   MAX_AW = 64;

  function automatic logic win_match(input logic [MAX_AW-1:0] adr,
                                     input logic [MAX_AW-1:0] base,
                                     input logic [MAX_AW-1:0] mask);
    return (adr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/rf68000_rr_arbiter.sv
// rtl/rf68000_rr_arbiter.sv - combinational rotating-priority grant; lock restricts to the port at ptr
module rf68000_rr_arbiter #(
  parameter int NPORT = 3,
  parameter int IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req,
  input  logic             lock,
  input  logic [IW-1:0]    ptr,
  output logic [NPORT-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < NPORT; k++) begin
      j = (int'(ptr) + k) % NPORT;
      if (!valid && req[j] && (!lock || k == 0)) begin
        valid  = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf68000_node_arbiter_mp.sv
// rtl/rf68000_node_arbiter_mp.sv - NPORT requesters onto one synchronous node RAM port
module rf68000_node_arbiter_mp
  import rf68000_node_pkg::*;
#(
  parameter int                  NPORT    = 3,
  parameter int                  DW       = 32,
  parameter int                  AW       = 32,
  parameter int                  RD_LAT   = 2,
  parameter logic [NPORT*AW-1:0] WIN_BASE = {NPORT{32'h0}},
  parameter logic [NPORT*AW-1:0] WIN_MASK = {NPORT{32'hFFFC0000}}
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [3:0]            id_i,
  input  logic [NPORT-1:0]      cyc_i,
  input  logic [NPORT-1:0]      stb_i,
  input  logic [NPORT-1:0]      we_i,
  input  logic [NPORT*DW/8-1:0] sel_i,
  input  logic [NPORT*AW-1:0]   adr_i,
  input  logic [NPORT*DW-1:0]   dat_i,
  output logic [NPORT-1:0]      ack_o,
  output logic [NPORT-1:0]      err_o,
  output logic [NPORT*DW-1:0]   dat_o,
  output logic                  ram_en_o,
  output logic [DW/8-1:0]       ram_we_o,
  output logic [AW-1:0]         ram_adr_o,
  output logic [DW-1:0]         ram_dat_o,
  input  logic [DW-1:0]         ram_dat_i,
  output logic                  busy_o
);

  localparam int SW = DW / 8;
  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  state_t              state_q, state_d;
  logic [NPORT-1:0]    req, win_ok, win_gnt;
  logic [NPORT-1:0]    ack_q, ack_d, err_q, err_d;
  logic [IW-1:0]       gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, gnt_nxt, arb_ptr, win_idx;
  logic                lock_q, lock_d, lock_hold, win_valid;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ram_en_q, ram_en_d;
  logic [SW-1:0]       ram_we_q, ram_we_d;
  logic [AW-1:0]       ram_adr_q, ram_adr_d;
  logic [DW-1:0]       ram_dat_q, ram_dat_d;
  logic [NPORT*DW-1:0] dat_q, dat_d;

  assign req       = cyc_i & stb_i;
  assign gnt_nxt   = (gnt_q == IW'(NPORT - 1)) ? '0 : gnt_q + IW'(1);
  assign lock_hold = lock_q & cyc_i[gnt_q];
  // A lock dropping this cycle already rotates priority past the old owner.
  assign arb_ptr   = lock_hold ? gnt_q : (lock_q ? gnt_nxt : rr_ptr_q);

  for (genvar i = 0; i < NPORT; i++) begin : g_win
    assign win_ok[i] = win_match(MAX_AW'(adr_i[i*AW +: AW]),
                                 MAX_AW'(WIN_BASE[i*AW +: AW] ^ {id_i, {(AW-4){1'b0}}}),
                                 MAX_AW'(WIN_MASK[i*AW +: AW]));
  end

  rf68000_rr_arbiter #(.NPORT(NPORT), .IW(IW)) u_arb (
    .req   (req),
    .lock  (lock_hold),
    .ptr   (arb_ptr),
    .gnt   (win_gnt),
    .idx   (win_idx),
    .valid (win_valid)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    err_d     = err_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    ram_en_d  = ram_en_q;
    ram_we_d  = ram_we_q;
    ram_adr_d = ram_adr_q;
    ram_dat_d = ram_dat_q;
    dat_d     = dat_q;

    if (lock_q && !cyc_i[gnt_q]) begin
      lock_d   = FALSE;
      rr_ptr_d = gnt_nxt;
    end

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          gnt_d  = win_idx;
          lock_d = TRUE;
          if (!win_ok[win_idx]) begin
            err_d   = win_gnt;
            state_d = ST_ACK;
          end else begin
            ram_en_d  = 1'b1;
            ram_adr_d = adr_i[int'(win_idx)*AW +: AW];
            if (we_i[win_idx]) begin
              ram_we_d  = sel_i[int'(win_idx)*SW +: SW];
              ram_dat_d = dat_i[int'(win_idx)*DW +: DW];
              state_d   = ST_WR;
            end else begin
              ram_we_d = '0;
              cnt_d    = CNT_W'(RD_LAT - 1);
              state_d  = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ram_en_d = 1'b0;
          if (req[gnt_q]) begin
            dat_d[int'(gnt_q)*DW +: DW] = ram_dat_i;
            ack_d   = NPORT'(1) << gnt_q;
            state_d = ST_ACK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WR: begin
        ram_we_d = '0;
        ram_en_d = 1'b0;
        if (req[gnt_q]) begin
          ack_d   = NPORT'(1) << gnt_q;
          state_d = ST_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        ram_en_d = 1'b0;
        if (!req[gnt_q]) begin
          ack_d   = '0;
          err_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ack_q     <= '0;
      err_q     <= '0;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      lock_q    <= FALSE;
      cnt_q     <= '0;
      ram_en_q  <= 1'b0;
      ram_we_q  <= '0;
      ram_adr_q <= '0;
      ram_dat_q <= '0;
      dat_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      ram_en_q  <= ram_en_d;
      ram_we_q  <= ram_we_d;
      ram_adr_q <= ram_adr_d;
      ram_dat_q <= ram_dat_d;
      dat_q     <= dat_d;
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign dat_o     = dat_q;
  assign ram_en_o  = ram_en_q;
  assign ram_we_o  = ram_we_q;
  assign ram_adr_o = ram_adr_q;
  assign ram_dat_o = ram_dat_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf68000_node_arbiter_mp.sv
// tb/tb_rf68000_node_arbiter_mp.sv - directed bench for the node RAM arbiter
module tb_rf68000_node_arbiter_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  id;
  logic [2:0]  cyc, stb, we, ack, err;
  logic [11:0] sel;
  logic [95:0] adr, dat, rd;
  logic        ram_en, busy;
  logic [3:0]  ram_we;
  logic [31:0] ram_adr, ram_wdat, ram_rdat;
  logic [31:0] mem [0:255];
  logic [2:0]  e;
  int          checks = 0;
  int          failures = 0;
  int          rr_exp [6] = '{1, 2, 0, 1, 2, 0};

  always #5 clk = ~clk;

  rf68000_node_arbiter_mp #(.NPORT(3), .DW(32), .AW(32), .RD_LAT(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_i(id), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .sel_i(sel), .adr_i(adr), .dat_i(dat), .ack_o(ack), .err_o(err), .dat_o(rd),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_dat_o(ram_wdat),
    .ram_dat_i(ram_rdat), .busy_o(busy)
  );

  // Synchronous RAM: one register stage, read-before-write.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[64]  <= 32'hDEADBEEF;
      mem[16]  <= 32'hCAFEF00D;
      ram_rdat <= '0;
    end else if (ram_en) begin
      ram_rdat <= mem[ram_adr[9:2]];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_adr[9:2]][8*b +: 8] <= ram_wdat[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while ((ack | err) == 3'b000 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 20) else begin
      failures++;
      $error("FAIL %s_timeout observed=%0d expected=<20", tag, n);
    end
  endtask

  task automatic req_port(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    we[p]          = w;
    adr[p*32 +: 32] = a;
    dat[p*32 +: 32] = d;
    sel[p*4 +: 4]   = s;
    cyc[p]          = 1'b1;
    stb[p]          = 1'b1;
  endtask

  task automatic drop(input int p);
    cyc[p] = 1'b0;
    stb[p] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; id = 4'h0; cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; dat = '0;
    tick();
    check("rst_ack", 64'(ack), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_ram_en", 64'(ram_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dat", 64'(rd[63:0]), 64'(0));
    rst_n = 1'b1;
    tick();

    // port1 read of 0x100: enable after 1 clock, ack after 3
    req_port(1, 1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    check("rd_ram_en", 64'(ram_en), 64'(1));
    check("rd_ram_adr", 64'(ram_adr), 64'h100);
    check("rd_busy", 64'(busy), 64'(1));
    tick();
    check("rd_no_early_ack", 64'(ack), 64'(0));
    tick();
    check("rd_ack", 64'(ack), 64'(3'b010));
    check("rd_data", 64'(rd[63:32]), 64'hDEADBEEF);
    check("rd_ram_en_off", 64'(ram_en), 64'(0));
    drop(1);
    tick();
    check("rd_ack_clear", 64'(ack), 64'(0));
    check("rd_idle", 64'(busy), 64'(0));

    // port0 partial write then readback
    req_port(0, 1'b1, 32'h40, 32'h55AA1234, 4'b0011);
    tick();
    check("wr_we", 64'(ram_we), 64'(4'b0011));
    check("wr_wdat", 64'(ram_wdat), 64'h55AA1234);
    tick();
    check("wr_we_off", 64'(ram_we), 64'(0));
    check("wr_ack", 64'(ack), 64'(3'b001));
    drop(0);
    tick();
    req_port(0, 1'b0, 32'h40, 32'h0, 4'hF);
    tick(); tick(); tick();
    check("rb_ack", 64'(ack), 64'(3'b001));
    check("rb_data", 64'(rd[31:0]), 64'hCAFE1234);
    drop(0);
    tick();

    // all three contend, single-beat cycles; pointer now at 1
    for (int p = 0; p < 3; p++) req_port(p, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      wait_ack("rr");
      e = 3'b001 << rr_exp[i];
      check("rr_order", 64'(ack), 64'(e));
      if (i == 5) begin
        cyc = '0; stb = '0;
        tick();
      end else begin
        drop(rr_exp[i]);
        tick();
        cyc[rr_exp[i]] = 1'b1;
        stb[rr_exp[i]] = 1'b1;
      end
    end

    // port2 locks four beats while port0 waits
    req_port(2, 1'b0, 32'h0, 32'h0, 4'hF);
    req_port(0, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      wait_ack("lock");
      check("lock_beat", 64'(ack), 64'(3'b100));
      stb[2] = 1'b0;
      tick();
      stb[2] = 1'b1;
    end
    drop(2);
    tick();
    wait_ack("lock_next");
    check("lock_next_port0", 64'(ack), 64'(3'b001));
    drop(0);
    tick();

    // out-of-window accesses terminate with err after one clock
    req_port(1, 1'b0, 32'hFFF00000, 32'h0, 4'hF);
    tick();
    check("err_flag", 64'(err), 64'(3'b010));
    check("err_no_ack", 64'(ack), 64'(0));
    check("err_no_ram", 64'(ram_en), 64'(0));
    drop(1);
    tick();
    check("err_clear", 64'(err), 64'(0));
    req_port(1, 1'b0, 32'h00040000, 32'h0, 4'hF);
    tick();
    check("err_edge", 64'(err), 64'(3'b010));
    drop(1);
    tick();

    // node id relocates the window
    id = 4'hF;
    req_port(1, 1'b0, 32'hF0000040, 32'h0, 4'hF);
    tick(); tick(); tick();
    check("id_ack", 64'(ack), 64'(3'b010));
    check("id_data", 64'(rd[63:32]), 64'hCAFE1234);
    drop(1);
    tick();
    id = 4'h0;

    // strobe withdrawn during read: no ack, back to idle
    req_port(1, 1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    drop(1);
    tick(); tick();
    check("abort_no_ack", 64'(ack), 64'(0));
    check("abort_idle", 64'(busy), 64'(0));
    check("abort_ram_off", 64'(ram_en), 64'(0));

    // asynchronous reset in the middle of a read
    req_port(0, 1'b0, 32'h100, 32'h0, 4'hF);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_ram_en", 64'(ram_en), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_dat", 64'(rd[63:0]), 64'(0));
    drop(0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_no_stale_ack", 64'(ack), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout observed=running expected=finished");
  end

endmodule
